// File: rtl/shift_rotate_seq_pkg.sv
// shift_rotate_seq_pkg: op and state encodings shared by the shift/rotate unit
package shift_rotate_seq_pkg;
  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } op_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
endpackage

// File: rtl/shift_rotate_seq_stage.sv
// shift_rotate_seq_stage: one log-network stage, shifts/rotates by 2**stage_i when enabled
module shift_rotate_seq_stage
  import shift_rotate_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic [WIDTH-1:0]         data_i,
  input  op_t                      op_i,
  input  logic [$clog2(CNT_W)-1:0] stage_i,
  input  logic                     en_i,
  output logic [WIDTH-1:0]         data_o
);
  logic [CNT_W:0]   sh, rsh;
  logic [WIDTH-1:0] sll, srl, rol, ror;
  always_comb begin
    sh     = (CNT_W+1)'(1) << stage_i;
    rsh    = (CNT_W+1)'(WIDTH) - sh;
    sll    = data_i << sh;
    srl    = data_i >> sh;
    rol    = sll | (data_i >> rsh);
    ror    = srl | (data_i << rsh);
    data_o = !en_i ? data_i :
             op_i == OP_ROL ? rol :
             op_i == OP_SLL ? sll :
             op_i == OP_ROR ? ror : srl;
  end
endmodule

// File: rtl/shift_rotate_seq.sv
// shift_rotate_seq: sequential shift/rotate unit, one log stage per clock under valid/ready
module shift_rotate_seq
  import shift_rotate_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [1:0]       in_op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  localparam int STG_W = $clog2(CNT_W);
  logic [1:0]       state_q, state_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic [WIDTH-1:0] data_q, data_d, step;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_t              op_q, op_d;
  logic             last;
  shift_rotate_seq_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_stage (
    .data_i (data_q),
    .op_i   (op_q),
    .stage_i(stage_q),
    .en_i   (cnt_q[stage_q]),
    .data_o (step)
  );
  always_comb begin
    last    = stage_q == STG_W'(CNT_W-1);
    state_d = state_q;
    stage_d = stage_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: if (in_valid && !flush) begin
        state_d = ST_SHIFT;
        stage_d = '0;
        data_d  = in_data;
        cnt_d   = in_cnt;
        op_d    = op_t'(in_op);
      end
      ST_SHIFT: begin
        state_d = flush ? ST_IDLE : last ? ST_DONE : ST_SHIFT;
        stage_d = stage_q + STG_W'(1);
        data_d  = step;
      end
      ST_DONE: state_d = (flush || out_ready) ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= OP_ROL;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end
  assign in_ready  = state_q == ST_IDLE;
  assign out_valid = state_q == ST_DONE;
  assign out_data  = data_q;
endmodule

// File: tb/tb_shift_rotate_seq.sv
// tb_shift_rotate_seq: directed and randomized checks against a cycle-level behavioural model
module tb_shift_rotate_seq;
  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0] in_data, out_data;
  logic [3:0]  in_cnt;
  logic [1:0]  in_op;
  int total = 0;
  int bad = 0;
  shift_rotate_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_cnt   (in_cnt),
    .in_op    (in_op),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] x, input int c);
    logic [31:0] d;
    case (op)
      2'b00: begin
        d = {x, x} << c;
        return d[31:16];
      end
      2'b01: return x << c;
      2'b10: begin
        d = {x, x} >> c;
        return d[15:0];
      end
      default: return x >> c;
    endcase
  endfunction
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  int          m_phase = 0;
  int          m_left = 0;
  logic [15:0] m_res = 0;
  bit          m_zero = 0;
  bit          armed = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_zero  = 1;
      armed   = 1;
    end else if (m_phase == 0) begin
      if (in_valid && !flush) begin
        m_phase = 1;
        m_left  = 4;
        m_res   = ref_op(in_op, in_data, int'(in_cnt));
        m_zero  = 0;
      end
    end else if (m_phase == 1) begin
      if (flush) m_phase = 0;
      else begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
    end else if (flush || out_ready) m_phase = 0;
  end
  always @(negedge clk) begin
    if (armed) begin
      check("m_in_ready", in_ready, m_phase == 0);
      check("m_out_valid", out_valid, m_phase == 2);
      if (m_phase == 2) check("m_out_data", out_data, m_res);
      else if (m_zero) check("m_out_data_rst", out_data, 0);
    end
  end
  task automatic directed(input logic [1:0] op, input logic [15:0] x, input logic [3:0] c,
                          input int hold, input logic [15:0] exp, input string nm);
    int k;
    in_valid  = 1;
    in_op     = op;
    in_data   = x;
    in_cnt    = c;
    out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    in_data  = 16'($urandom);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_lat"}, k, 4);
    check({nm, "_data"}, out_data, exp);
    repeat (hold) begin
      @(negedge clk);
      check({nm, "_hold_data"}, out_data, exp);
      check({nm, "_hold_valid"}, out_valid, 1);
      check({nm, "_hold_ready"}, in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check({nm, "_idle"}, in_ready, 1);
    check({nm, "_novalid"}, out_valid, 0);
  endtask
  initial begin
    int combo;
    int k;
    bit acc;
    rst = 1; in_valid = 0; in_data = 0; in_cnt = 0; in_op = 0; flush = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    rst = 0;
    @(negedge clk);
    directed(2'b00, 16'h8001, 4'd1, 0, 16'h0003, "rol1");
    directed(2'b01, 16'h00F0, 4'd4, 0, 16'h0F00, "sll4");
    directed(2'b11, 16'hF000, 4'd12, 0, 16'h000F, "srl12");
    directed(2'b10, 16'h0001, 4'd1, 0, 16'h8000, "ror1");
    directed(2'b00, 16'hBEEF, 4'd0, 0, 16'hBEEF, "rol0");
    directed(2'b11, 16'hBEEF, 4'd0, 0, 16'hBEEF, "srl0");
    directed(2'b00, 16'h1234, 4'd15, 0, 16'h091A, "rol15");
    directed(2'b10, 16'h1234, 4'd4, 3, 16'h4123, "ror4_bp");
    // flush on the second SHIFT edge
    in_valid = 1; in_op = 2'b00; in_data = 16'hFFFF; in_cnt = 4'd3;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    check("flush_ready", in_ready, 1);
    check("flush_valid", out_valid, 0);
    repeat (6) begin
      @(negedge clk);
      check("flush_never_valid", out_valid, 0);
    end
    directed(2'b11, 16'hF000, 4'd12, 0, 16'h000F, "after_flush");
    in_valid = 1; in_op = 2'b10; in_data = 16'h0001; in_cnt = 4'd1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst = 1; in_valid = 1;
    @(negedge clk);
    check("rst_shift_valid", out_valid, 0);
    check("rst_shift_data", out_data, 0);
    check("rst_shift_ready", in_ready, 1);
    rst = 0; in_valid = 0;
    @(negedge clk);
    in_valid = 1; in_op = 2'b01; in_data = 16'h00FF; in_cnt = 4'd8;
    @(negedge clk);
    in_valid = 0;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rst_done_reach", out_valid, 1);
    check("rst_done_pre_data", out_data, 16'hFF00);
    rst = 1; in_valid = 1;
    @(negedge clk);
    check("rst_done_valid", out_valid, 0);
    check("rst_done_data", out_data, 0);
    check("rst_done_ready", in_ready, 1);
    rst = 0; in_valid = 0;
    @(negedge clk);
    combo = 0;
    for (int i = 0; i < 3000; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      in_op     = 2'(combo >> 4);
      in_cnt    = 4'(combo);
      in_data   = 16'($urandom);
      out_ready = $urandom_range(0, 1) == 1;
      flush     = $urandom_range(0, 29) == 0;
      acc = in_valid && in_ready && !flush;
      @(negedge clk);
      if (acc) combo = (combo + 1) % 64;
    end
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
